full_adder: RTL and testbench

Parameterizable-width binary full adder with a registered result, used as the arithmetic leaf cell in datapath blocks.
- Adds two WIDTH-bit operands and a carry-in through a ripple chain of 1-bit full-adder cells.
- Captures sum and carry-out in an output register qualified by a valid strobe.
- Default WIDTH=1 gives the classic single-bit full adder with one cycle of latency.

---
 rtl/full_adder.sv | 125 ++++++++++++
 tb/tb_full_adder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// full_adder
// ----------
// Parameterisable-width binary adder built from a ripple chain of 1-bit
// full-adder cells, with an optional output register qualified by a valid
// strobe. It serves as the arithmetic leaf cell of datapath blocks.
//
// Parameters
//   WIDTH   : operand / sum width in bits (1..64)
//   REG_OUT : 1 = sum/carryOut/outValid registered (1-cycle latency)
//             0 = purely combinational; clk/resetN unused, outValid = inValid
//
// Ports
//   clk      in   rising-edge clock
//   resetN   in   asynchronous active-low reset
//   a, b     in   WIDTH-bit operands
//   carryIn  in   carry into bit 0
//   inValid  in   operands valid; captured on rising clk when high
//   sum      out  (a + b + carryIn) mod 2^WIDTH
//   carryOut out  carry out of bit WIDTH-1
//   outValid out  sum/carryOut hold a freshly captured result
//   overflow out  signed two's-complement overflow (only with the macro)
//
// Build option
//   FULL_ADDER_OVF_EN : when defined, adds the 'overflow' output port,
//                       computed as c[WIDTH] ^ c[WIDTH-1] and timed like sum.
//
// Handshake: a result is accepted on every rising edge where inValid is high
// (no backpressure); outValid is high for exactly the cycle after each such
// edge, so back-to-back operands yield back-to-back results.

module full_adder #(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryIn,
  input  logic             inValid,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut,
`ifdef FULL_ADDER_OVF_EN
  output logic             overflow,
`endif
  output logic             outValid
);

  // Ripple carry chain: c[i] is the carry into cell i, c[WIDTH] the carry out.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = carryIn;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

`ifdef FULL_ADDER_OVF_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  logic ovf_comb;
  assign ovf_comb = c[WIDTH] ^ c[WIDTH-1];
`endif

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             valid_q, valid_d;
`ifdef FULL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Results are only loaded when inValid is high; otherwise the held value
    // is selected, so X on the operands while idle cannot reach the outputs.
    always_comb begin
      sum_d   = sum_q;
      cout_d  = cout_q;
      valid_d = inValid;
`ifdef FULL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      if (inValid) begin
        sum_d  = s;
        cout_d = c[WIDTH];
`ifdef FULL_ADDER_OVF_EN
        ovf_d  = ovf_comb;
`endif
      end
    end

    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        sum_q   <= '0;
        cout_q  <= 1'b0;
        valid_q <= 1'b0;
`ifdef FULL_ADDER_OVF_EN
        ovf_q   <= 1'b0;
`endif
      end else begin
        sum_q   <= sum_d;
        cout_q  <= cout_d;
        valid_q <= valid_d;
`ifdef FULL_ADDER_OVF_EN
        ovf_q   <= ovf_d;
`endif
      end
    end

    assign sum      = sum_q;
    assign carryOut = cout_q;
    assign outValid = valid_q;
`ifdef FULL_ADDER_OVF_EN
    assign overflow = ovf_q;
`endif
  end else begin : g_comb
    assign sum      = s;
    assign carryOut = c[WIDTH];
    assign outValid = inValid;
`ifdef FULL_ADDER_OVF_EN
    assign overflow = ovf_comb;
`endif
  end

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder
// -------------
// Directed bench for full_adder. Three instances share one clock:
//   u1 : WIDTH=1, REG_OUT=1  (truth table, async reset)
//   u8 : WIDTH=8, REG_OUT=1  (boundaries, hold, back-to-back, overflow)
//   u4 : WIDTH=4, REG_OUT=0  (combinational path)
// Expected values below are hand-computed constants.

module tb_full_adder;

  // ---------------- clock / reset ----------------
  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // u1 signals
  logic       rst1_n, a1, b1, cin1, v1;
  logic       s1, co1, ov1;
  // u8 signals
  logic       rst8_n, cin8, v8;
  logic [7:0] a8, b8, s8;
  logic       co8, ov8;
  // u4 signals
  logic       rst4_n, cin4, v4;
  logic [3:0] a4, b4, s4;
  logic       co4, ov4;

`ifdef FULL_ADDER_OVF_EN
  logic ovf1, ovf8, ovf4;
`endif

  full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u1 (
    .clk(clk), .resetN(rst1_n), .a(a1), .b(b1), .carryIn(cin1), .inValid(v1),
    .sum(s1), .carryOut(co1),
`ifdef FULL_ADDER_OVF_EN
    .overflow(ovf1),
`endif
    .outValid(ov1)
  );

  full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u8 (
    .clk(clk), .resetN(rst8_n), .a(a8), .b(b8), .carryIn(cin8), .inValid(v8),
    .sum(s8), .carryOut(co8),
`ifdef FULL_ADDER_OVF_EN
    .overflow(ovf8),
`endif
    .outValid(ov8)
  );

  full_adder #(.WIDTH(4), .REG_OUT(1'b0)) u4 (
    .clk(clk), .resetN(rst4_n), .a(a4), .b(b4), .carryIn(cin4), .inValid(v4),
    .sum(s4), .carryOut(co4),
`ifdef FULL_ADDER_OVF_EN
    .overflow(ovf4),
`endif
    .outValid(ov4)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  logic [1:0] tt_exp [8];
  logic [7:0] tt_ovf;

  initial begin
    // {carryOut,sum} for {a,b,carryIn} = 0..7
    tt_exp[0] = 2'b00; tt_exp[1] = 2'b01; tt_exp[2] = 2'b01; tt_exp[3] = 2'b10;
    tt_exp[4] = 2'b01; tt_exp[5] = 2'b10; tt_exp[6] = 2'b10; tt_exp[7] = 2'b11;
    // overflow = carryIn ^ carryOut: set only for combos 1 and 6
    tt_ovf = 8'b0100_0010;

    rst1_n = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; v1 = 1'b0;
    rst8_n = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; v8 = 1'b0;
    rst4_n = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0; v4 = 1'b0;

    #1;
    check("w1_reset_sum", 64'(s1), 64'd0);
    check("w1_reset_cout", 64'(co1), 64'd0);
    check("w1_reset_valid", 64'(ov1), 64'd0);
    check("w8_reset_sum", 64'(s8), 64'd0);
    check("w8_reset_valid", 64'(ov8), 64'd0);

    step();
    rst1_n = 1'b1; rst8_n = 1'b1; rst4_n = 1'b1;
    step();
    check("w1_idle_valid", 64'(ov1), 64'd0);

    // ---- WIDTH=1 truth table, back-to-back ----
    for (int i = 0; i < 8; i++) begin
      {a1, b1, cin1} = 3'(i);
      v1 = 1'b1;
      step();
      check($sformatf("w1_tt%0d_cout_sum", i), 64'({co1, s1}), 64'(tt_exp[i]));
      check($sformatf("w1_tt%0d_valid", i), 64'(ov1), 64'd1);
`ifdef FULL_ADDER_OVF_EN
      check($sformatf("w1_tt%0d_ovf", i), 64'(ovf1), 64'(tt_ovf[i]));
`endif
    end

    // ---- async reset between edges after 1+1+1 captured ----
    #2;
    rst1_n = 1'b0;
    #1;
    check("w1_async_sum", 64'(s1), 64'd0);
    check("w1_async_cout", 64'(co1), 64'd0);
    check("w1_async_valid", 64'(ov1), 64'd0);
`ifdef FULL_ADDER_OVF_EN
    check("w1_async_ovf", 64'(ovf1), 64'd0);
`endif
    #1;
    rst1_n = 1'b1;
    v1 = 1'b0;
    step();
    check("w1_post_reset_valid", 64'(ov1), 64'd0);
    check("w1_post_reset_sum", 64'(s1), 64'd0);
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0; v1 = 1'b1;
    step();
    check("w1_post_reset_result", 64'({co1, s1}), 64'b01);
    check("w1_post_reset_valid1", 64'(ov1), 64'd1);
    v1 = 1'b0;

    // ---- WIDTH=8 boundaries ----
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; v8 = 1'b1;
    step();
    check("w8_ff_01_sum", 64'(s8), 64'h00);
    check("w8_ff_01_cout", 64'(co8), 64'd1);
`ifdef FULL_ADDER_OVF_EN
    check("w8_ff_01_ovf", 64'(ovf8), 64'd0);
`endif
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    step();
    check("w8_ff_ff_1_sum", 64'(s8), 64'hFF);
    check("w8_ff_ff_1_cout", 64'(co8), 64'd1);
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    step();
    check("w8_zero_sum", 64'(s8), 64'h00);
    check("w8_zero_cout", 64'(co8), 64'd0);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
    step();
    check("w8_b2b0_sum", 64'(s8), 64'h46);
    check("w8_b2b0_valid", 64'(ov8), 64'd1);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
    step();
    check("w8_80_80_sum", 64'(s8), 64'h00);
    check("w8_80_80_cout", 64'(co8), 64'd1);
`ifdef FULL_ADDER_OVF_EN
    check("w8_80_80_ovf", 64'(ovf8), 64'd1);
`endif

    // ---- WIDTH=8 pulse then hold for 3 idle cycles ----
    a8 = 8'h3C; b8 = 8'h05; cin8 = 1'b1; v8 = 1'b1;
    step();
    check("w8_pulse_sum", 64'(s8), 64'h42);
    check("w8_pulse_cout", 64'(co8), 64'd0);
    check("w8_pulse_valid", 64'(ov8), 64'd1);
    v8 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a8 = (k == 1) ? 8'hxx : 8'($urandom_range(0, 255));
      b8 = 8'($urandom_range(0, 255));
      cin8 = (k == 2) ? 1'bx : 1'b1;
      step();
      check($sformatf("w8_hold%0d_sum", k), 64'(s8), 64'h42);
      check($sformatf("w8_hold%0d_cout", k), 64'(co8), 64'd0);
      check($sformatf("w8_hold%0d_valid", k), 64'(ov8), 64'd0);
    end

`ifdef FULL_ADDER_OVF_EN
    // ---- signed overflow cases ----
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; v8 = 1'b1;
    step();
    check("w8_7f_01_sum", 64'(s8), 64'h80);
    check("w8_7f_01_ovf", 64'(ovf8), 64'd1);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    step();
    check("w8_10_20_sum", 64'(s8), 64'h30);
    check("w8_10_20_ovf", 64'(ovf8), 64'd0);
    v8 = 1'b0;
`endif

    // ---- WIDTH=4 combinational path, no clock edge needed ----
    @(negedge clk);
    a4 = 4'h9; b4 = 4'h8; cin4 = 1'b1; v4 = 1'b0;
    #1;
    check("w4_9_8_1_sum", 64'(s4), 64'h2);
    check("w4_9_8_1_cout", 64'(co4), 64'd1);
    check("w4_valid_low", 64'(ov4), 64'd0);
`ifdef FULL_ADDER_OVF_EN
    check("w4_9_8_1_ovf", 64'(ovf4), 64'd1);
`endif
    v4 = 1'b1;
    #1;
    check("w4_valid_high", 64'(ov4), 64'd1);
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
    #1;
    check("w4_ff_1_sum", 64'(s4), 64'hF);
    check("w4_ff_1_cout", 64'(co4), 64'd1);
    a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
    rst4_n = 1'b0;
    #1;
    check("w4_zero_in_reset_sum", 64'(s4), 64'h0);
    check("w4_zero_in_reset_cout", 64'(co4), 64'd0);
    a4 = 4'h5; b4 = 4'h6;
    #1;
    check("w4_reset_no_effect_sum", 64'(s4), 64'hB);
    check("w4_reset_no_effect_valid", 64'(ov4), 64'd1);
    rst4_n = 1'b1;

    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
